// File: rtl/multi_tube_store.sv
// multi_tube_store
//   A bank of N_TUBES "tubes", each holding TUBE_DEPTH lines of LINE_LENGTH
//   bits, with a free-running scan beam and a two-state SCAN/ACTION FSM.
//   Every SCAN cycle the beam advances by one line and may clear bits of the
//   scanned line in every tube. A request sampled in SCAN is carried out in
//   the following ACTION cycle (read, merge-write or overwrite, always
//   read-before-write), after which the FSM returns to SCAN.
//
//   Optional build macro: MULTI_TUBE_STORE_ADDR_CHECK_EN
//     defined   : tube index >= N_TUBES raises w_ERR alongside w_ACK.
//     undefined : w_ERR is tied low; out-of-range accesses still write
//                 nothing and return zero (no tube decodes them).
//
// Ports
//   w_CLK        in   clock, rising edge
//   w_RST        in   asynchronous active-high reset
//   w_REQ        in   action request, sampled in SCAN only
//   b_OP         in   00 read, 01 merge-write, 10 overwrite, 11 read
//   b_ADDR       in   {tube index, word index}
//   b_DATA_IN    in   write data
//   b_ZERO       in   per-bit clear mask (merge-write and scan-clear)
//   w_SCAN_CLR   in   clear the scanned line in every tube this SCAN cycle
//   b_DATA_OUT   out  registered pre-write line value, held until next ACK
//   w_ACK        out  one-cycle pulse after each action
//   w_BUSY       out  high while in ACTION
//   b_SCAN_ADDR  out  current beam position
//   w_ERR        out  out-of-range tube flag (only with the macro defined)

module multi_tube_store #(
  parameter int LINE_LENGTH = 40,
  parameter int TUBE_DEPTH  = 32,
  parameter int N_TUBES     = 2,
  parameter int TUBE_BITS   = 5,
  localparam int WORD_BITS  = $clog2(TUBE_DEPTH)
) (
  input  logic                           w_CLK,
  input  logic                           w_RST,
  input  logic                           w_REQ,
  input  logic [1:0]                     b_OP,
  input  logic [TUBE_BITS+WORD_BITS-1:0] b_ADDR,
  input  logic [LINE_LENGTH-1:0]         b_DATA_IN,
  input  logic [LINE_LENGTH-1:0]         b_ZERO,
  input  logic                           w_SCAN_CLR,
  output logic [LINE_LENGTH-1:0]         b_DATA_OUT,
  output logic                           w_ACK,
  output logic                           w_BUSY,
  output logic [WORD_BITS-1:0]           b_SCAN_ADDR,
  output logic                           w_ERR
);

  typedef enum logic {
    SCAN   = 1'b0,
    ACTION = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [1:0]             op_reg;
  logic [TUBE_BITS-1:0]   tube_reg;
  logic [WORD_BITS-1:0]   word_reg;
  logic [LINE_LENGTH-1:0] data_reg;
  logic [LINE_LENGTH-1:0] zero_reg;
  logic [WORD_BITS-1:0]   scan_addr_reg;
  logic [LINE_LENGTH-1:0] data_out_reg;
  logic                   ack_reg;
  logic                   busy_reg;

  // Action-side datapath: old value of the addressed line and its update.
  logic [LINE_LENGTH-1:0] act_old;
  logic [LINE_LENGTH-1:0] act_new;
  logic                   act_we;
  logic [LINE_LENGTH-1:0] tube_act_rd [N_TUBES];

  // Tube storage. Each tube has one write per cycle: the action write in
  // ACTION, the scan-clear in SCAN. Reads are combinational so that the
  // read-modify-write of both paths completes in a single cycle. Writes are
  // gated by reset so a reset held across the ACTION edge aborts the write;
  // the contents themselves are never reset.
  genvar gi;
  generate
    for (gi = 0; gi < N_TUBES; gi++) begin : g_tube
      logic [LINE_LENGTH-1:0] mem [TUBE_DEPTH];
      logic                   hit;
      logic [LINE_LENGTH-1:0] scan_old;

      assign hit             = (tube_reg == TUBE_BITS'(gi));
      assign scan_old        = mem[scan_addr_reg];
      assign tube_act_rd[gi] = mem[word_reg];

      always_ff @(posedge w_CLK) begin
        if (!w_RST) begin
          if (state_reg == ACTION) begin
            if (act_we && hit) begin
              mem[word_reg] <= act_new;
            end
          end else if (w_SCAN_CLR) begin
            mem[scan_addr_reg] <= scan_old & ~b_ZERO;
          end
        end
      end
    end
  endgenerate

  // Tube select. A tube index with no matching tube leaves act_old at zero,
  // which is exactly the out-of-range read value.
  always_comb begin
    act_old = '0;
    for (int i = 0; i < N_TUBES; i++) begin
      if (tube_reg == TUBE_BITS'(i)) begin
        act_old = tube_act_rd[i];
      end
    end
  end

  always_comb begin
    act_we  = 1'b0;
    act_new = data_reg;
    case (op_reg)
      2'b01: begin
        act_we  = 1'b1;
        act_new = data_reg | (act_old & ~zero_reg);
      end
      2'b10: begin
        act_we  = 1'b1;
      end
      default: begin
        act_we  = 1'b0;
      end
    endcase
  end

`ifdef MULTI_TUBE_STORE_ADDR_CHECK_EN
  logic err_reg;
  logic addr_bad;

  assign addr_bad = (int'(tube_reg) >= N_TUBES);
  assign w_ERR    = err_reg;

  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) begin
      err_reg <= 1'b0;
    end else begin
      // Pulses with the ACK produced by the ACTION cycle.
      err_reg <= (state_reg == ACTION) && addr_bad;
    end
  end
`else
  assign w_ERR = 1'b0;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) begin
      state_reg     <= SCAN;
      op_reg        <= 2'b00;
      tube_reg      <= '0;
      word_reg      <= '0;
      data_reg      <= '0;
      zero_reg      <= '0;
      scan_addr_reg <= '0;
      data_out_reg  <= '0;
      ack_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        SCAN: begin
          ack_reg       <= 1'b0;
          // Power-of-two depth: natural wrap from TUBE_DEPTH-1 to 0.
          scan_addr_reg <= scan_addr_reg + 1'b1;
          if (w_REQ) begin
            op_reg    <= b_OP;
            tube_reg  <= b_ADDR[TUBE_BITS+WORD_BITS-1:WORD_BITS];
            word_reg  <= b_ADDR[WORD_BITS-1:0];
            data_reg  <= b_DATA_IN;
            zero_reg  <= b_ZERO;
            state_reg <= ACTION;
            busy_reg  <= 1'b1;
          end
        end
        ACTION: begin
          // Beam holds; w_REQ is not looked at here.
          data_out_reg <= act_old;
          ack_reg      <= 1'b1;
          state_reg    <= SCAN;
          busy_reg     <= 1'b0;
        end
        default: begin
          state_reg <= SCAN;
          busy_reg  <= 1'b0;
          ack_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign b_DATA_OUT  = data_out_reg;
  assign w_ACK       = ack_reg;
  assign w_BUSY      = busy_reg;
  assign b_SCAN_ADDR = scan_addr_reg;

endmodule

// File: tb/tb_multi_tube_store.sv
module tb_multi_tube_store;

  logic        w_CLK;
  logic        w_RST;
  logic        w_REQ;
  logic [1:0]  b_OP;
  logic [9:0]  b_ADDR;
  logic [39:0] b_DATA_IN;
  logic [39:0] b_ZERO;
  logic        w_SCAN_CLR;
  logic [39:0] b_DATA_OUT;
  logic        w_ACK;
  logic        w_BUSY;
  logic [4:0]  b_SCAN_ADDR;
  logic        w_ERR;

  multi_tube_store dut (
    .w_CLK       (w_CLK),
    .w_RST       (w_RST),
    .w_REQ       (w_REQ),
    .b_OP        (b_OP),
    .b_ADDR      (b_ADDR),
    .b_DATA_IN   (b_DATA_IN),
    .b_ZERO      (b_ZERO),
    .w_SCAN_CLR  (w_SCAN_CLR),
    .b_DATA_OUT  (b_DATA_OUT),
    .w_ACK       (w_ACK),
    .w_BUSY      (w_BUSY),
    .b_SCAN_ADDR (b_SCAN_ADDR),
    .w_ERR       (w_ERR)
  );

  typedef struct {
    logic [39:0] data;
    logic        err;
    int          cyc;
    string       name;
  } sb_t;

  sb_t sb [$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  initial w_CLK = 1'b0;
  always #5 w_CLK = ~w_CLK;

  always @(posedge w_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one action; expected response goes to the scoreboard with the
  // cycle at which the ACK must appear (two edges after the sample edge).
  task automatic act(input logic [1:0] op, input int tube, input int word,
                     input logic [39:0] data, input logic [39:0] zero,
                     input logic [39:0] exp_data, input string name);
    sb_t e;
    e.data = exp_data;
`ifdef MULTI_TUBE_STORE_ADDR_CHECK_EN
    e.err  = (tube >= 2);
`else
    e.err  = 1'b0;
`endif
    e.cyc  = cyc + 2;
    e.name = name;
    sb.push_back(e);
    b_OP      = op;
    b_ADDR    = {5'(tube), 5'(word)};
    b_DATA_IN = data;
    b_ZERO    = zero;
    w_REQ     = 1'b1;
    @(posedge w_CLK); #1;
    w_REQ     = 1'b0;
    @(posedge w_CLK); #1;
    $display("act %s op=%0d tube=%0d word=%0d data=%h zero=%h", name, op, tube, word, data, zero);
  endtask

  // Monitor: pops and compares whenever the DUT acknowledges.
  initial begin
    sb_t e;
    forever begin
      @(negedge w_CLK);
      if (w_ACK === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack=1 expected no ack (cyc=%0d)", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_data"}, 64'(b_DATA_OUT), 64'(e.data));
          check({e.name, "_err"},  64'(w_ERR),      64'(e.err));
          check({e.name, "_lat"},  64'(cyc),        64'(e.cyc));
          $display("ack %s data=%h err=%b cyc=%0d", e.name, b_DATA_OUT, w_ERR, cyc);
        end
      end
    end
  end

  initial begin
    int  k;
    bit  found;
    w_RST      = 1'b1;
    w_REQ      = 1'b0;
    b_OP       = 2'b00;
    b_ADDR     = '0;
    b_DATA_IN  = '0;
    b_ZERO     = '0;
    w_SCAN_CLR = 1'b0;

    @(posedge w_CLK); #1;
    check("rst_data_out", 64'(b_DATA_OUT),  64'h0);
    check("rst_ack",      64'(w_ACK),       64'h0);
    check("rst_busy",     64'(w_BUSY),      64'h0);
    check("rst_scan",     64'(b_SCAN_ADDR), 64'h0);
    check("rst_err",      64'(w_ERR),       64'h0);
    w_RST = 1'b0;

    // Idle scan for TUBE_DEPTH+1 beats; the beam clears every line as it
    // goes so that later reads of never-written lines have known contents.
    w_SCAN_CLR = 1'b1;
    b_ZERO     = 40'hFF_FFFF_FFFF;
    for (int i = 1; i <= 33; i++) begin
      @(posedge w_CLK); #1;
      check($sformatf("scan_%0d", i), 64'(b_SCAN_ADDR), 64'(i % 32));
      check($sformatf("scan_busy_%0d", i), 64'(w_BUSY), 64'h0);
    end
    w_SCAN_CLR = 1'b0;
    b_ZERO     = '0;

    // Overwrite then read back.
    act(2'b10, 1, 3, 40'hAA_AAAA_AAAA, 40'h0, 40'h0,           "ovw_t1w3");
    act(2'b00, 1, 3, 40'h0,            40'h0, 40'hAA_AAAA_AAAA, "rd_t1w3");

    // Merge-write returns the old line and keeps old bits outside the mask.
    act(2'b10, 0, 7, 40'hFF_00FF_00FF, 40'h0,           40'h0,           "ovw_t0w7");
    act(2'b01, 0, 7, 40'h00_0000_0001, 40'hF0_0000_0000, 40'hFF_00FF_00FF, "mrg_t0w7");
    act(2'b11, 0, 7, 40'h0,            40'h0,           40'h0F_00FF_00FF, "rd3_t0w7");

    // Scan-clear of word 5 in both tubes.
    act(2'b10, 0, 5, 40'hFF_FFFF_FFFF, 40'h0, 40'h0, "ovw_t0w5");
    act(2'b10, 1, 5, 40'hFF_FFFF_FFFF, 40'h0, 40'h0, "ovw_t1w5");
    act(2'b10, 0, 4, 40'h12_3456_7890, 40'h0, 40'h0, "ovw_t0w4");
    act(2'b10, 0, 6, 40'h0A_0B0C_0D0E, 40'h0, 40'h0, "ovw_t0w6");
    found = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (b_SCAN_ADDR == 5'd5) begin
        found = 1'b1;
        break;
      end
      @(posedge w_CLK); #1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL scan_reach5: got beam=%0d expected 5 within 40 cycles", b_SCAN_ADDR);
    end
    w_SCAN_CLR = 1'b1;
    b_ZERO     = 40'h00_0000_00FF;
    @(posedge w_CLK); #1;
    w_SCAN_CLR = 1'b0;
    b_ZERO     = '0;
    $display("scan_clr beam=5 zero=00000000ff");
    act(2'b00, 0, 5, 40'h0, 40'h0, 40'hFF_FFFF_FF00, "rd_t0w5");
    act(2'b00, 1, 5, 40'h0, 40'h0, 40'hFF_FFFF_FF00, "rd_t1w5");
    act(2'b00, 0, 4, 40'h0, 40'h0, 40'h12_3456_7890, "rd_t0w4");
    act(2'b00, 0, 6, 40'h0, 40'h0, 40'h0A_0B0C_0D0E, "rd_t0w6");
    act(2'b00, 1, 3, 40'h0, 40'h0, 40'hAA_AAAA_AAAA, "rd2_t1w3");

    // Out-of-range tube: no write, zero data.
    act(2'b10, 3, 3, 40'h55_5555_5555, 40'h0, 40'h0, "ovw_oor_t3w3");
    act(2'b00, 1, 3, 40'h0, 40'h0, 40'hAA_AAAA_AAAA, "rd3_t1w3");
    act(2'b00, 0, 3, 40'h0, 40'h0, 40'h0,            "rd_t0w3");

    // Continuous request: an ACK every second cycle, BUSY alternating.
    begin
      sb_t e;
      for (int j = 1; j <= 3; j++) begin
        e.data = 40'hAA_AAAA_AAAA;
        e.err  = 1'b0;
        e.cyc  = cyc + 2 * j;
        e.name = $sformatf("cont_%0d", j);
        sb.push_back(e);
      end
    end
    b_OP   = 2'b00;
    b_ADDR = {5'd1, 5'd3};
    w_REQ  = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge w_CLK); #1;
      check($sformatf("cont_busy_%0d", j), 64'(w_BUSY), 64'(j % 2));
    end
    w_REQ = 1'b0;
    @(posedge w_CLK); #1;
    check("cont_busy_6", 64'(w_BUSY), 64'h0);

    // Reset in the middle of an ACTION: no ACK, line unchanged.
    b_OP      = 2'b10;
    b_ADDR    = {5'd1, 5'd3};
    b_DATA_IN = 40'h12_3451_2345;
    w_REQ     = 1'b1;
    @(posedge w_CLK); #1;
    w_REQ = 1'b0;
    check("mid_busy", 64'(w_BUSY), 64'h1);
    w_RST = 1'b1;
    #1;
    check("mid_rst_busy",     64'(w_BUSY),      64'h0);
    check("mid_rst_ack",      64'(w_ACK),       64'h0);
    check("mid_rst_scan",     64'(b_SCAN_ADDR), 64'h0);
    check("mid_rst_data_out", 64'(b_DATA_OUT),  64'h0);
    check("mid_rst_err",      64'(w_ERR),       64'h0);
    @(posedge w_CLK); #1;
    w_RST = 1'b0;
    $display("reset during action");
    @(posedge w_CLK); #1;
    check("post_rst_data_out", 64'(b_DATA_OUT), 64'h0);
    act(2'b00, 1, 3, 40'h0, 40'h0, 40'hAA_AAAA_AAAA, "rd_after_rst");

    repeat (3) @(posedge w_CLK);
    #1;
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_tube_store.md
MULTI_TUBE_STORE -- requirements
Module: multi_tube_store

Interface
REQ-001 Parameter LINE_LENGTH, default 40, SHALL set the word width in bits.
REQ-002 Parameter TUBE_DEPTH, default 32, SHALL set the number of lines per tube (power of two, >=2).
REQ-003 Parameter N_TUBES, default 2, SHALL set the number of tubes (1..32).
REQ-004 Parameter TUBE_BITS, default 5, SHALL set the tube-index field width; WORD_BITS SHALL be derived as clog2(TUBE_DEPTH).
REQ-005 w_CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 w_RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-007 w_REQ  in  1  SHALL be the action request, sampled only in SCAN state.
REQ-008 b_OP  in  2  SHALL select the operation: 00 read, 01 merge-write, 10 overwrite, 11 read.
REQ-009 b_ADDR  in  TUBE_BITS+WORD_BITS  SHALL carry the address: tube index in the MSBs, word index in the LSBs.
REQ-010 b_DATA_IN  in  LINE_LENGTH  SHALL carry the write data.
REQ-011 b_ZERO  in  LINE_LENGTH  SHALL be the per-bit clear mask for merge-write and scan-clear.
REQ-012 w_SCAN_CLR  in  1  SHALL enable clearing of the scanned line in every tube.
REQ-013 b_DATA_OUT  out  LINE_LENGTH  SHALL carry the registered read data.
REQ-014 w_ACK  out  1  SHALL pulse for one cycle when an action completes.
REQ-015 w_BUSY  out  1  SHALL be high while in ACTION state.
REQ-016 b_SCAN_ADDR  out  WORD_BITS  SHALL expose the current beam position.
REQ-017 w_ERR  out  1  SHALL flag an out-of-range tube access (see Configuration).

Function
REQ-018 The FSM SHALL have exactly two states: SCAN and ACTION.
REQ-019 In SCAN with w_REQ=0, the FSM SHALL stay in SCAN; with w_REQ=1, it SHALL latch b_OP/b_ADDR/b_DATA_IN/b_ZERO and move to ACTION.
REQ-020 Every SCAN cycle SHALL increment b_SCAN_ADDR, wrapping from TUBE_DEPTH-1 to 0.
REQ-021 In a SCAN cycle with w_SCAN_CLR=1, line b_SCAN_ADDR (pre-increment value) of every tube SHALL become old & ~b_ZERO.
REQ-022 The ACTION cycle SHALL perform the latched operation and return unconditionally to SCAN; back-to-back actions are impossible, so throughput is one action per 2 cycles.
REQ-023 Read data SHALL be the pre-write line value for all ops (read-before-write).
REQ-024 Merge-write SHALL store b_DATA_IN | (old & ~b_ZERO); overwrite SHALL store b_DATA_IN.
REQ-025 b_DATA_OUT and w_ACK SHALL be registered in the ACTION cycle, giving visibility one cycle after the ACTION edge: latency from the w_REQ sample edge is 2 edges.
REQ-026 b_DATA_OUT SHALL hold its value until the next ACK; it is zero between reset and the first ACK.
REQ-027 The beam SHALL NOT advance and SHALL NOT clear in ACTION cycles.
REQ-028 Changes to w_REQ while in ACTION SHALL be ignored.

Reset
REQ-029 Asserting w_RST at any time SHALL immediately force: state SCAN, b_SCAN_ADDR 0, b_DATA_OUT 0, w_ACK 0, w_BUSY 0, w_ERR 0.
REQ-030 Reset mid-ACTION SHALL abort the pending write (line unchanged) and produce no ACK.
REQ-031 Tube contents SHALL NOT be reset.

Configuration
REQ-032 Macro MULTI_TUBE_STORE_ADDR_CHECK_EN defined: a tube index >= N_TUBES SHALL suppress the write, return 0 on b_DATA_OUT, and assert w_ERR together with w_ACK for one cycle.
REQ-033 Macro undefined: out-of-range writes SHALL still be suppressed and return 0, but w_ERR SHALL be tied to 0 and no checking logic SHALL be present.

Verification
REQ-034 Reset, then overwrite 0xAAAAAAAAAA at tube 1 word 3, then read it back -> ACK 2 edges after each request; readback 0xAAAAAAAAAA.
REQ-035 Line = 0xFF00FF00FF; merge-write DATA_IN=0x0000000001, ZERO=0xF000000000 -> stored 0x0F00FF00FF; the returned data is 0xFF00FF00FF.
REQ-036 Hold w_REQ=0 for TUBE_DEPTH+1 cycles -> SCAN_ADDR runs 0..31 then wraps to 0; w_BUSY stays 0.
REQ-037 Tubes 0 and 1 word 5 = all-ones; set w_SCAN_CLR=1 with ZERO=0x00000000FF for the beat at SCAN_ADDR 5 -> both lines read 0xFFFFFFFF00; other lines unchanged.
REQ-038 w_REQ held high continuously -> ACK every second cycle; w_BUSY alternates 0/1.
REQ-039 With the macro defined, N_TUBES=2: write to tube 3 -> w_ERR=1 with w_ACK, DATA_OUT 0, no line modified; assert w_RST during an ACTION -> no ACK, target line unchanged.
